// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: groups the byte handshake, status strobes and PS/2 pad signals of the host transmitter.
// Latency: none, wires only.
// Backpressure: TX_READY from the transmitter gates TX_VALID; pads carry raw inputs and pull-low enables.
// Ports: master = system/pad side (drives TX_DATA, TX_VALID, PS2_*_IN), slave = transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic       TX_DONE;
   logic       TX_ERROR;
   logic       TX_BUSY;
   logic       PS2_CLK_IN;
   logic       PS2_DATA_IN;
   logic       PS2_CLK_OE;
   logic       PS2_DATA_OE;

   modport master (
      output TX_DATA, TX_VALID, PS2_CLK_IN, PS2_DATA_IN,
      input  TX_READY, TX_DONE, TX_ERROR, TX_BUSY, PS2_CLK_OE, PS2_DATA_OE
   );

   modport slave (
      input  TX_DATA, TX_VALID, PS2_CLK_IN, PS2_DATA_IN,
      output TX_READY, TX_DONE, TX_ERROR, TX_BUSY, PS2_CLK_OE, PS2_DATA_OE
   );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter, sends one command byte over open-drain CLK/DATA.
// Latency: INHIBIT_CYCLES + 1 request cycles, then 11 device clocks; DONE/ERROR once the line idles or the timer expires.
// Backpressure: TX_READY drops the cycle after acceptance and returns the cycle after DONE/ERROR; TX_VALID is ignored meanwhile.
// Ports: CLK_25MHZ system clock; RESET_N async active-low; bus (ps2_host_tx_if.slave): TX_DATA/TX_VALID/TX_READY
//        byte handshake, TX_DONE/TX_ERROR 1-cycle result strobes, TX_BUSY, PS2_*_IN raw pads, PS2_*_OE pull-low enables.
`timescale 1ns/1ps
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 2500,
   parameter int unsigned TIMEOUT_CYCLES = 375000,
   parameter int unsigned FILTER_LEN     = 8
) (
   input  logic         CLK_25MHZ,
   input  logic         RESET_N,
   ps2_host_tx_if.slave bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int IW = $clog2(INHIBIT_CYCLES + 1);

   typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_f, fall;
   logic [FW-1:0] flt_cnt;

   state_t        state;
   logic [IW-1:0] inh_cnt;
   logic [18:0]   timer;
   logic [3:0]    bit_cnt;
   logic [9:0]    shreg;
   logic          ok;
   logic          timed_out;
   logic          tx_ready, tx_done, tx_error, tx_busy, clk_oe, data_oe;

   // Synchronisers and clock glitch filter. Idle line level is high, so reset to 1.
   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         clk_s1  <= 1'b1;
         clk_s2  <= 1'b1;
         dat_s1  <= 1'b1;
         dat_s2  <= 1'b1;
         clk_f   <= 1'b1;
         flt_cnt <= '0;
         fall    <= 1'b0;
      end else begin
         clk_s1 <= bus.PS2_CLK_IN;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.PS2_DATA_IN;
         dat_s2 <= dat_s1;
         fall   <= 1'b0;
         if (clk_s2 == clk_f) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            // FILTER_LEN consecutive differing samples: accept the new level.
            // The new level differs from clk_f, so clk_f==1 here means a falling edge.
            flt_cnt <= '0;
            clk_f   <= clk_s2;
            fall    <= clk_f;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign timed_out = (timer == 19'(TIMEOUT_CYCLES - 1));

   // Protocol FSM. All pad enables and status outputs are registered so reset clears them asynchronously.
   always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         state    <= IDLE;
         inh_cnt  <= '0;
         timer    <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         ok       <= 1'b0;
         tx_ready <= 1'b1;
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         tx_busy  <= 1'b0;
         clk_oe   <= 1'b0;
         data_oe  <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         tx_error <= 1'b0;
         case (state)
            IDLE: begin
               // The first IDLE cycle after a transfer carries the DONE/ERROR pulse with READY still low,
               // so a held TX_VALID cannot be re-accepted until READY has visibly returned.
               tx_ready <= 1'b1;
               tx_busy  <= 1'b0;
               clk_oe   <= 1'b0;
               data_oe  <= 1'b0;
               if (bus.TX_VALID && tx_ready) begin
                  shreg    <= {1'b1, ~^bus.TX_DATA, bus.TX_DATA};
                  tx_ready <= 1'b0;
                  tx_busy  <= 1'b1;
                  clk_oe   <= 1'b1;
                  inh_cnt  <= '0;
                  state    <= INHIBIT;
               end
            end
            INHIBIT: begin
               // Clock held low alone for INHIBIT_CYCLES cycles; the start bit then joins it for one REQ cycle.
               if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                  data_oe <= 1'b1;
                  state   <= REQ;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            REQ: begin
               clk_oe  <= 1'b0;
               timer   <= '0;
               bit_cnt <= '0;
               state   <= SEND;
            end
            SEND, ACK, WAIT_IDLE: begin
               timer <= fall ? '0 : timer + 1'b1;
               if (timed_out) begin
                  // Timeout wins over a coincident fall.
                  clk_oe   <= 1'b0;
                  data_oe  <= 1'b0;
                  tx_error <= 1'b1;
                  state    <= IDLE;
               end else if (state == SEND) begin
                  if (fall) begin
                     // Falls 1..10 present data LSB first, parity, then stop (release).
                     data_oe <= ~shreg[0];
                     shreg   <= {1'b0, shreg[9:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 4'd9) state <= ACK;
                  end
               end else if (state == ACK) begin
                  if (fall) begin
                     ok    <= ~dat_s2;
                     state <= WAIT_IDLE;
                  end
               end else if (clk_f && dat_s2) begin
                  tx_done  <= ok;
                  tx_error <= ~ok;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.TX_READY    = tx_ready;
   assign bus.TX_DONE     = tx_done;
   assign bus.TX_ERROR    = tx_error;
   assign bus.TX_BUSY     = tx_busy;
   assign bus.PS2_CLK_OE  = clk_oe;
   assign bus.PS2_DATA_OE = data_oe;
endmodule
